// File: rtl/dd_fx3_pkg.sv
// Shared types and limits for the FX3 transfer controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dd_fx3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } xferState_t;

    localparam int DEFAULT_BURST_WORDS = 8192;
    localparam int MAX_READ_LATENCY    = 4;

endpackage

// File: rtl/fx3_transfer_controller_read_delay.sv
// Delays the FX3 read strobe so the data generator qualifies the word FX3 actually samples.
// Latency: READ_LATENCY fx3Clk cycles, output taken straight from the last flop.
// Backpressure: none; free-running shift register that keeps shifting in every state.
module fx3ReadDelay
    import dd_fx3_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic fx3Clk,
    input  logic nReset,
    input  logic readData,
    output logic fx3isReading
);

    logic [READ_LATENCY-1:0] pipe_q;
    logic [READ_LATENCY-1:0] pipe_d;

    // Shift the strobe one stage per cycle; stage 0 captures the live strobe.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = readData;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline registers, cleared asynchronously so a reset mid-burst drops the qualifier at once.
    always_ff @(posedge fx3Clk or negedge nReset) begin
        if (!nReset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign fx3isReading = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/fx3_transfer_controller.sv
// Moves exactly one BURST_WORDS burst from the show-ahead sample FIFO per FX3 read handshake.
// Latency: fifoRdReq is combinational (0 cycles) from readData; dataAvailable is registered (1 cycle).
// Backpressure: FX3 paces the burst with readData; an empty FIFO mid-burst only flags underrun. Optional stats: FX3_XFER_STATS_EN.
module fx3_transfer_controller
    import dd_fx3_pkg::*;
#(
    parameter int BURST_WORDS  = DEFAULT_BURST_WORDS,
    parameter int USEDW_WIDTH  = 14,
    parameter int READ_LATENCY = 2
) (
    input  logic                   fx3Clk,
    input  logic                   nReset,
    input  logic                   collectData,
    input  logic                   readData,
    input  logic [USEDW_WIDTH-1:0] fifoUsedw,
    input  logic                   fifoEmpty,
    output logic                   fifoRdReq,
    output logic                   dataAvailable,
    output logic                   fx3isReading,
    output logic                   underrunError,
    output logic                   overrunError
`ifdef FX3_XFER_STATS_EN
    ,
    output logic [31:0]            burstCount,
    output logic [31:0]            stallCycles
`endif
);

    localparam int                   CNT_W     = $clog2(BURST_WORDS) + 1;
    localparam logic [CNT_W-1:0]     BURST_CNT = CNT_W'(BURST_WORDS);
    localparam logic [CNT_W-1:0]     ONE_CNT   = CNT_W'(1);
    localparam logic [USEDW_WIDTH:0] BURST_LVL = (USEDW_WIDTH + 1)'(BURST_WORDS);

    xferState_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             avail_q, avail_d;
    logic             under_q, under_d;
    logic             over_q, over_d;
    logic             burst_ready;

    assign burst_ready = ({1'b0, fifoUsedw} >= BURST_LVL);

    // Next-state, word counting and error capture. The ARMED cycle that accepts the
    // handshake already carries the first word (show-ahead FIFO), so it is counted and popped.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        avail_d   = 1'b0;
        under_d   = under_q;
        over_d    = over_q;
        fifoRdReq = 1'b0;
        case (state_q)
            IDLE: begin
                if (collectData) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                avail_d = burst_ready;
                if (readData && avail_q && collectData) begin
                    fifoRdReq = ~fifoEmpty;
                    if (fifoEmpty) begin
                        under_d = 1'b1;
                    end
                    if (ONE_CNT == BURST_CNT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = ONE_CNT;
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                fifoRdReq = readData & ~fifoEmpty;
                if (readData) begin
                    if (fifoEmpty) begin
                        under_d = 1'b1;
                    end
                    if (cnt_q + ONE_CNT == BURST_CNT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + ONE_CNT;
                    end
                end
            end
            DONE: begin
                // Any strobe still high here is asking for a word past the burst.
                if (readData) begin
                    over_d = 1'b1;
                end else begin
                    state_d = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
        // Losing the capture enable flushes everything except the strobe delay line.
        if (!collectData) begin
            state_d = IDLE;
            cnt_d   = '0;
            avail_d = 1'b0;
            under_d = 1'b0;
            over_d  = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge fx3Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            avail_q <= 1'b0;
            under_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            avail_q <= avail_d;
            under_q <= under_d;
            over_q  <= over_d;
        end
    end

    assign dataAvailable = avail_q;
    assign underrunError = under_q;
    assign overrunError  = over_q;

    fx3ReadDelay #(
        .READ_LATENCY(READ_LATENCY)
    ) u_read_delay (
        .fx3Clk      (fx3Clk),
        .nReset      (nReset),
        .readData    (readData),
        .fx3isReading(fx3isReading)
    );

`ifdef FX3_XFER_STATS_EN
    logic [31:0] bursts_q;
    logic [31:0] stalls_q;

    // Completed-burst and starved-ARMED counters; both wrap and clear with the capture enable.
    always_ff @(posedge fx3Clk or negedge nReset) begin
        if (!nReset) begin
            bursts_q <= '0;
            stalls_q <= '0;
        end else if (!collectData) begin
            bursts_q <= '0;
            stalls_q <= '0;
        end else begin
            if (state_d == DONE && state_q != DONE) begin
                bursts_q <= bursts_q + 32'd1;
            end
            if (state_q == ARMED && !avail_q) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign burstCount  = bursts_q;
    assign stallCycles = stalls_q;
`endif

endmodule

// File: tb/tb_fx3_transfer_controller.sv
module tb_fx3_transfer_controller;

    localparam int BW  = 8192;
    localparam int LAT = 2;

    logic        fx3Clk = 1'b0;
    logic        nReset;
    logic        collectData;
    logic        readData;
    logic [13:0] fifoUsedw;
    logic        fifoEmpty;
    logic        fifoRdReq;
    logic        dataAvailable;
    logic        fx3isReading;
    logic        underrunError;
    logic        overrunError;
`ifdef FX3_XFER_STATS_EN
    logic [31:0] burstCount;
    logic [31:0] stallCycles;
`endif

    int   checks   = 0;
    int   failures = 0;
    logic sb_q[$];
    bit   sb_en    = 1'b0;
    logic exp_rd;

    always #5 fx3Clk = ~fx3Clk;

    fx3_transfer_controller #(
        .BURST_WORDS (BW),
        .USEDW_WIDTH (14),
        .READ_LATENCY(LAT)
    ) dut (
        .fx3Clk       (fx3Clk),
        .nReset       (nReset),
        .collectData  (collectData),
        .readData     (readData),
        .fifoUsedw    (fifoUsedw),
        .fifoEmpty    (fifoEmpty),
        .fifoRdReq    (fifoRdReq),
        .dataAvailable(dataAvailable),
        .fx3isReading (fx3isReading),
        .underrunError(underrunError),
        .overrunError (overrunError)
`ifdef FX3_XFER_STATS_EN
        ,
        .burstCount   (burstCount),
        .stallCycles  (stallCycles)
`endif
    );

    // Scoreboard: the strobe clocked in at each edge is queued; the delayed qualifier must replay it.
    always @(posedge fx3Clk) begin
        if (sb_en) begin
            sb_q.push_back(readData);
            #1;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL fx3isReading_sb: scoreboard empty at %0t", $time);
            end else begin
                exp_rd = sb_q.pop_front();
                if (fx3isReading !== exp_rd) begin
                    failures++;
                    $display("FAIL fx3isReading_sb: got %b expected %b at %0t", fx3isReading, exp_rd, $time);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic sb_restart();
        sb_q.delete();
        for (int i = 0; i < LAT - 1; i++) sb_q.push_back(1'b0);
    endtask

    task automatic drive(input logic rd, input logic emp, output logic req);
        readData  = rd;
        fifoEmpty = emp;
        #1;
        req = fifoRdReq;
        @(posedge fx3Clk);
        #1;
    endtask

    task automatic run_words(input int n, output int pulses);
        logic r;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, r);
            if (r) pulses++;
        end
    endtask

    task automatic test_reset();
        logic r;
        nReset = 1'b0; collectData = 1'b0; readData = 1'b0; fifoUsedw = '0; fifoEmpty = 1'b0;
        repeat (3) @(posedge fx3Clk);
        #1;
        checks++;
        if ({dataAvailable, fifoRdReq, fx3isReading, underrunError, overrunError} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {dataAvailable, fifoRdReq, fx3isReading, underrunError, overrunError});
        end
        nReset = 1'b1;
        sb_restart();
        sb_en = 1'b1;
        drive(1'b0, 1'b0, r);
        checks++;
        if ({dataAvailable, r, underrunError, overrunError} !== 4'b0) begin
            failures++;
            $display("FAIL idle_outputs: got %b expected 0000", {dataAvailable, r, underrunError, overrunError});
        end
`ifdef FX3_XFER_STATS_EN
        checks++;
        if (burstCount !== 32'd0 || stallCycles !== 32'd0) begin
            failures++;
            $display("FAIL reset_stats: got %0d/%0d expected 0/0", burstCount, stallCycles);
        end
`endif
    endtask

    task automatic test_arm();
        logic r;
        collectData = 1'b1;
        fifoUsedw   = 14'(BW - 1);
        repeat (3) drive(1'b0, 1'b0, r);
        checks++;
        if (dataAvailable !== 1'b0) begin
            failures++;
            $display("FAIL avail_below_burst: got %b expected 0", dataAvailable);
        end
        fifoUsedw = 14'(BW);
        drive(1'b0, 1'b0, r);
        checks++;
        if (dataAvailable !== 1'b1) begin
            failures++;
            $display("FAIL avail_at_burst: got %b expected 1", dataAvailable);
        end
    endtask

    task automatic test_burst();
        logic r;
        int   pulses = 0;
        for (int i = 0; i < BW; i++) begin
            drive(1'b1, 1'b0, r);
            if (r) pulses++;
            if (i == 0) begin
                checks++;
                if (dataAvailable !== 1'b1) begin
                    failures++;
                    $display("FAIL avail_on_entry: got %b expected 1", dataAvailable);
                end
            end
            if (i == 1) begin
                checks++;
                if (dataAvailable !== 1'b0) begin
                    failures++;
                    $display("FAIL avail_drop: got %b expected 0", dataAvailable);
                end
            end
        end
        checks++;
        if (pulses != BW) begin
            failures++;
            $display("FAIL burst_pulses: got %0d expected %0d", pulses, BW);
        end
        checks++;
        if (underrunError !== 1'b0 || overrunError !== 1'b0) begin
            failures++;
            $display("FAIL burst_errors: got %b%b expected 00", underrunError, overrunError);
        end
        drive(1'b0, 1'b0, r);
        checks++;
        if (r !== 1'b0 || dataAvailable !== 1'b0) begin
            failures++;
            $display("FAIL done_to_armed: got req=%b avail=%b expected 0 0", r, dataAvailable);
        end
        drive(1'b0, 1'b0, r);
        checks++;
        if (dataAvailable !== 1'b1) begin
            failures++;
            $display("FAIL avail_rearm: got %b expected 1", dataAvailable);
        end
    endtask

    task automatic test_overrun();
        logic r;
        int   pulses;
        run_words(BW, pulses);
        drive(1'b1, 1'b0, r);
        checks++;
        if (pulses != BW || r !== 1'b0) begin
            failures++;
            $display("FAIL overrun_req: got pulses=%0d req=%b expected %0d 0", pulses, r, BW);
        end
        checks++;
        if (overrunError !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: got %b expected 1", overrunError);
        end
        repeat (3) drive(1'b1, 1'b0, r);
        drive(1'b0, 1'b0, r);
        checks++;
        if (overrunError !== 1'b1 || underrunError !== 1'b0) begin
            failures++;
            $display("FAIL overrun_sticky: got ovr=%b und=%b expected 1 0", overrunError, underrunError);
        end
        collectData = 1'b0;
        drive(1'b0, 1'b0, r);
        checks++;
        if (overrunError !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: got %b expected 0", overrunError);
        end
        collectData = 1'b1;
        drive(1'b0, 1'b0, r);
        drive(1'b0, 1'b0, r);
    endtask

    task automatic test_underrun();
        logic r;
        int   pulses;
        run_words(100, pulses);
        drive(1'b1, 1'b1, r);
        checks++;
        if (r !== 1'b0) begin
            failures++;
            $display("FAIL underrun_req: got %b expected 0", r);
        end
        checks++;
        if (underrunError !== 1'b1 || pulses != 100) begin
            failures++;
            $display("FAIL underrun_set: got err=%b pulses=%0d expected 1 100", underrunError, pulses);
        end
        run_words(5, pulses);
        collectData = 1'b0;
        drive(1'b0, 1'b0, r);
        checks++;
        if (underrunError !== 1'b0) begin
            failures++;
            $display("FAIL underrun_clear: got %b expected 0", underrunError);
        end
        drive(1'b1, 1'b0, r);
        checks++;
        if (r !== 1'b0 || dataAvailable !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignores_read: got req=%b avail=%b expected 0 0", r, dataAvailable);
        end
        drive(1'b0, 1'b0, r);
        collectData = 1'b1;
        drive(1'b0, 1'b0, r);
        drive(1'b0, 1'b0, r);
    endtask

    task automatic test_reset_mid_burst();
        logic r;
        int   pulses;
        run_words(4000, pulses);
        #1;
        sb_en  = 1'b0;
        nReset = 1'b0;
        #1;
        checks++;
        if ({dataAvailable, fifoRdReq, fx3isReading, underrunError, overrunError} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_burst: got %b expected 00000",
                     {dataAvailable, fifoRdReq, fx3isReading, underrunError, overrunError});
        end
        @(posedge fx3Clk);
        #1;
        readData = 1'b0;
        nReset   = 1'b1;
        sb_restart();
        sb_en = 1'b1;
        drive(1'b0, 1'b0, r);
        drive(1'b0, 1'b0, r);
        checks++;
        if (dataAvailable !== 1'b1) begin
            failures++;
            $display("FAIL rearm_after_reset: got %b expected 1", dataAvailable);
        end
        run_words(BW, pulses);
        drive(1'b0, 1'b0, r);
        checks++;
        if (pulses != BW || underrunError !== 1'b0 || overrunError !== 1'b0) begin
            failures++;
            $display("FAIL fresh_burst: got pulses=%0d errs=%b%b expected %0d 00",
                     pulses, underrunError, overrunError, BW);
        end
        drive(1'b0, 1'b0, r);
    endtask

    task automatic test_back_to_back();
        logic r;
        int   pulses;
        collectData = 1'b0;
        drive(1'b0, 1'b0, r);
        collectData = 1'b1;
        drive(1'b0, 1'b0, r);
        drive(1'b0, 1'b0, r);
        for (int b = 0; b < 3; b++) begin
            run_words(BW, pulses);
            checks++;
            if (pulses != BW) begin
                failures++;
                $display("FAIL b2b_pulses: burst %0d got %0d expected %0d", b, pulses, BW);
            end
            drive(1'b0, 1'b0, r);
            checks++;
            if (dataAvailable !== 1'b0) begin
                failures++;
                $display("FAIL b2b_reentry_avail: burst %0d got %b expected 0", b, dataAvailable);
            end
            drive(1'b0, 1'b0, r);
            checks++;
            if (dataAvailable !== 1'b1) begin
                failures++;
                $display("FAIL b2b_reassert: burst %0d got %b expected 1", b, dataAvailable);
            end
        end
`ifdef FX3_XFER_STATS_EN
        checks++;
        if (burstCount !== 32'd3) begin
            failures++;
            $display("FAIL burst_count: got %0d expected 3", burstCount);
        end
`endif
    endtask

`ifdef FX3_XFER_STATS_EN
    task automatic test_stats_stall();
        logic r;
        collectData = 1'b0;
        drive(1'b0, 1'b0, r);
        fifoUsedw   = '0;
        collectData = 1'b1;
        drive(1'b0, 1'b0, r);
        repeat (50) drive(1'b0, 1'b0, r);
        checks++;
        if (stallCycles !== 32'd50 || burstCount !== 32'd0) begin
            failures++;
            $display("FAIL stall_cycles: got stall=%0d bursts=%0d expected 50 0", stallCycles, burstCount);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_arm();
        test_burst();
        test_overrun();
        test_underrun();
        test_reset_mid_burst();
        test_back_to_back();
`ifdef FX3_XFER_STATS_EN
        test_stats_stall();
`endif
        sb_en = 1'b0;
        #20;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fx3_transfer_controller.md
# fx3_transfer_controller

Sequences 16-bit burst transfers from the sample FIFO to the FX3 GPIF slave interface on the FX3 clock domain. It watches FIFO fill level, raises `dataAvailable` when a full burst is buffered, issues FIFO read requests while the FX3 strobes `readData`, and counts words so that exactly one burst leaves per handshake. It also flags protocol errors. It sits between the data generator's output FIFO and the FX3 control pins in the top level.

## Interface
- `BURST_WORDS`, 8192: words per FX3 transfer; power of two, ≤ FIFO depth.
- `USEDW_WIDTH`, 14: width of FIFO fill-level input.
- `READ_LATENCY`, 2: fx3Clk cycles from `readData` sampled high to FX3 sampling the bus; range 1–4.

Ports:
- `fx3Clk` input 1: FX3 clock (64 MHz). One clock; reset is asynchronous and active-low.
- `nReset` input 1: asynchronous active-low reset.
- `collectData` input 1: capture enable from FX3; low flushes the controller to IDLE.
- `readData` input 1: FX3 read strobe, synchronous to `fx3Clk`.
- `fifoUsedw` input USEDW_WIDTH: FIFO words stored.
- `fifoEmpty` input 1: FIFO empty flag.
- `fifoRdReq` output 1: FIFO read request (show-ahead FIFO).
- `dataAvailable` output 1: burst ready, to FX3 CTL_00.
- `fx3isReading` output 1: `readData` delayed READ_LATENCY cycles; drives the data generator's read qualifier.
- `underrunError` output 1: sticky; FIFO was empty during a burst read.
- `overrunError` output 1: sticky; FX3 read beyond BURST_WORDS.

## Operation
- States: IDLE, ARMED, BURST, DONE.
- IDLE: all outputs low. Go to ARMED when `collectData`=1.
- ARMED: `dataAvailable`=1 while `fifoUsedw` ≥ BURST_WORDS; otherwise 0. Go to BURST on the first sampled `readData`=1 while `dataAvailable`=1.
- BURST: `fifoRdReq` = `readData` & ~`fifoEmpty`.
  - Word counter (log2(BURST_WORDS)+1 bits) increments on each cycle with `readData`=1.
  - `dataAvailable` drops the cycle after BURST entry.
  - At count = BURST_WORDS, go to DONE and clear the counter.
- DONE: `fifoRdReq`=0. Wait for `readData`=0, then go to ARMED.
- Errors:
  - `readData`=1 with `fifoEmpty`=1 in BURST sets `underrunError`.
  - `readData`=1 in DONE on the cycle after the last counted word sets `overrunError`.
  - Both errors clear only on reset or `collectData` falling.
- `collectData`=0 in any state: next state IDLE, counter cleared, errors cleared. `fx3isReading` pipeline keeps flushing.
- `readData` in IDLE is ignored. `readData` in ARMED with `dataAvailable`=0 is ignored and raises no error.

## Timing
- Reset value of every output and register: 0; state IDLE.
- `dataAvailable` is registered: it rises 1 cycle after `fifoUsedw` crosses BURST_WORDS in ARMED.
- `fifoRdReq` is combinational from registered state and the `readData` input, so there is zero-cycle latency to the FIFO.
- `fx3isReading` is a READ_LATENCY-deep shift register of `readData`.
- A burst occupies BURST_WORDS `readData` cycles, plus ≥1 DONE cycle.
- Back-to-back bursts: `dataAvailable` can reassert at the earliest 1 cycle after ARMED re-entry.
- Reset asserted mid-burst: immediate IDLE; FIFO contents are not touched.

## Configuration
- `FX3_XFER_STATS_EN` defined: adds outputs `burstCount[31:0]` and `stallCycles[31:0]`.
  - `burstCount` increments on each BURST→DONE transition.
  - `stallCycles` increments on each ARMED cycle with `dataAvailable`=0.
  - Both wrap at 2^32 and clear on reset or `collectData` falling.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Package `dd_fx3_pkg`: state enum `xferState_t` (IDLE, ARMED, BURST, DONE), default BURST_WORDS constant, maximum READ_LATENCY constant.
- Sub-module `fx3ReadDelay`: parameterised READ_LATENCY shift register with async active-low reset, producing `fx3isReading`.

## Test plan
- Reset, `collectData`=1, `fifoUsedw`=8191 → `dataAvailable`=0. Set 8192 → `dataAvailable`=1 one cycle later.
- Armed, `readData` held 8192 cycles, FIFO never empty → exactly 8192 `fifoRdReq` pulses, DONE, no errors. `fx3isReading` lags `readData` by 2 cycles.
- Hold `readData` for 8193 cycles → `overrunError`=1 and stays 1. `fifoRdReq` stays 0 after word 8192.
- Force `fifoEmpty`=1 at word 100 → `underrunError`=1, no `fifoRdReq` that cycle. Drop `collectData` → error clears, state IDLE.
- Pulse `nReset` low at word 4000 → all outputs 0 immediately. Re-arm → a fresh 8192-word burst completes.
- With `FX3_XFER_STATS_EN`, run 3 bursts → `burstCount`=3. Hold `fifoUsedw`=0 for 50 armed cycles → `stallCycles`=50.
